// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed byte image, writes it
// into instruction memory word by word, then releases the core from reset.
module imem_boot_loader #(
    parameter int                 ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = ADDR_W'(32'h0000_0000),
    parameter int unsigned        MAX_WORDS = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_LEN0, S_LEN1, S_DATA, S_CSUM, S_CHK, S_RUN, S_ERR
    } state_t;

    state_t             state_reg, state_next;
    logic [15:0]        len_reg, len_next;
    logic [15:0]        idx_reg, idx_next;
    logic [1:0]         lane_reg, lane_next;
    logic [7:0]         xor_reg, xor_next;
    logic [23:0]        word_reg, word_next;
    logic [7:0]         csum_reg, csum_next;
    logic               we_reg, we_next;
    logic [ADDR_W-1:0]  addr_reg, addr_next;
    logic [31:0]        wdata_reg, wdata_next;
    logic               core_rst_reg, core_rst_next;
    logic               done_reg, done_next;
    logic               error_reg, error_next;

    logic               xfer;
    logic [15:0]        n_full;

    assign byte_ready = !rst && (state_reg inside {S_LEN0, S_LEN1, S_DATA, S_CSUM});
    assign xfer       = byte_valid && byte_ready;
    assign n_full     = {byte_data, len_reg[7:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_LEN0;
            len_reg      <= '0;
            idx_reg      <= '0;
            lane_reg     <= '0;
            xor_reg      <= '0;
            word_reg     <= '0;
            csum_reg     <= '0;
            we_reg       <= 1'b0;
            addr_reg     <= BASE_ADDR;
            wdata_reg    <= '0;
            core_rst_reg <= 1'b1;
            done_reg     <= 1'b0;
            error_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            len_reg      <= len_next;
            idx_reg      <= idx_next;
            lane_reg     <= lane_next;
            xor_reg      <= xor_next;
            word_reg     <= word_next;
            csum_reg     <= csum_next;
            we_reg       <= we_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
            core_rst_reg <= core_rst_next;
            done_reg     <= done_next;
            error_reg    <= error_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        len_next   = len_reg;
        idx_next   = idx_reg;
        lane_next  = lane_reg;
        xor_next   = xor_reg;
        word_next  = word_reg;
        csum_next  = csum_reg;
        we_next    = 1'b0;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;

        case (state_reg)
            S_LEN0: if (xfer) begin
                len_next[7:0] = byte_data;
                xor_next      = xor_reg ^ byte_data;
                state_next    = S_LEN1;
            end
            S_LEN1: if (xfer) begin
                len_next[15:8] = byte_data;
                xor_next       = xor_reg ^ byte_data;
                if (32'(n_full) > MAX_WORDS)
                    state_next = S_ERR;
                else if (n_full == 16'd0)
                    state_next = S_CSUM;
                else
                    state_next = S_DATA;
            end
            S_DATA: if (xfer) begin
                xor_next  = xor_reg ^ byte_data;
                lane_next = lane_reg + 2'd1;
                case (lane_reg)
                    2'd0: word_next[7:0]   = byte_data;
                    2'd1: word_next[15:8]  = byte_data;
                    2'd2: word_next[23:16] = byte_data;
                    default: begin
                        // Fourth byte completes the word: issue the write next cycle.
                        wdata_next = {byte_data, word_reg};
                        addr_next  = BASE_ADDR + ADDR_W'({idx_reg, 2'b00});
                        we_next    = 1'b1;
                        idx_next   = idx_reg + 16'd1;
                        if (idx_reg == len_reg - 16'd1)
                            state_next = S_CSUM;
                    end
                endcase
            end
            S_CSUM: if (xfer) begin
                csum_next  = byte_data;
                state_next = S_CHK;
            end
            S_CHK:   state_next = (csum_reg == xor_reg) ? S_RUN : S_ERR;
            default: state_next = state_reg;
        endcase

        done_next     = (state_next == S_RUN);
        error_next    = (state_next == S_ERR);
        core_rst_next = (state_next != S_RUN);
    end

    assign imem_we    = we_reg;
    assign imem_addr  = addr_reg;
    assign imem_wdata = wdata_reg;
    assign core_rst   = core_rst_reg;
    assign done       = done_reg;
    assign error      = error_reg;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: stimulus queues expected writes and
// final status; a negedge monitor pops and compares whenever the DUT presents them.
module tb_imem_boot_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rst;
    logic        done;
    logic        error;

    int total = 0;
    int bad   = 0;

    logic [63:0] exp_wr[$];   // {addr, data}
    logic [2:0]  exp_res[$];  // {done, error, core_rst}
    logic [7:0]  stim[$];
    logic        seen_res = 1'b0;

    imem_boot_loader #(.ADDR_W(32), .BASE_ADDR(32'h0), .MAX_WORDS(64)) dut (
        .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .core_rst(core_rst), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst) begin
            seen_res = 1'b0;
        end else begin
            if (imem_we) begin
                total++;
                if (exp_wr.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_write got addr=%h data=%h want none", imem_addr, imem_wdata);
                end else begin
                    logic [63:0] e;
                    e = exp_wr.pop_front();
                    if ({imem_addr, imem_wdata} !== e) begin
                        bad++;
                        $display("FAIL write got addr=%h data=%h want addr=%h data=%h",
                                 imem_addr, imem_wdata, e[63:32], e[31:0]);
                    end else
                        $display("write addr=%h data=%h ok", imem_addr, imem_wdata);
                end
            end
            if ((done || error) && !seen_res) begin
                seen_res = 1'b1;
                total++;
                if (exp_res.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_result got done/error/core_rst=%b want none", {done, error, core_rst});
                end else begin
                    logic [2:0] r;
                    r = exp_res.pop_front();
                    if ({done, error, core_rst} !== r) begin
                        bad++;
                        $display("FAIL result got done/error/core_rst=%b want %b", {done, error, core_rst}, r);
                    end else
                        $display("result done/error/core_rst=%b ok", r);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s got %h want %h", name, act, req);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we"},      32'(imem_we),  32'd0);
        check({tag, "_addr"},    imem_addr,     32'h0);
        check({tag, "_wdata"},   imem_wdata,    32'h0);
        check({tag, "_core_rst"},32'(core_rst), 32'd1);
        check({tag, "_done"},    32'(done),     32'd0);
        check({tag, "_error"},   32'(error),    32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_byte_ready", 32'(byte_ready), 32'd0);
        @(posedge clk);
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Sends stim[]; gap inserts one idle cycle between bytes; lat adds edge-timing checks.
    task automatic run_image(input bit gap, input bit lat);
        for (int i = 0; i < stim.size(); i++) begin
            send_byte(stim[i]);
            if (lat && i == 4) check("we_before_4th", 32'(imem_we), 32'd0);
            if (lat && i == 5) check("we_after_4th", 32'(imem_we), 32'd1);
            if (lat && i == stim.size() - 1) begin
                check("core_rst_chk_cycle", 32'(core_rst), 32'd1);
                @(posedge clk);
                #1;
                check("core_rst_fall", 32'(core_rst), 32'd0);
                check("done_rise", 32'(done), 32'd1);
            end
            if (gap && i != stim.size() - 1) @(posedge clk);
        end
    endtask

    task automatic finish_image(input string tag, input logic [2:0] want);
        int k;
        k = 0;
        while (!(done || error) && k < 8) begin
            @(posedge clk);
            #1;
            k++;
        end
        total++;
        if (!(done || error)) begin
            bad++;
            $display("FAIL %s_timeout got done=0 error=0 want completion", tag);
        end
        @(negedge clk);
        @(posedge clk);
        #1;
        check({tag, "_wr_left"},  32'(exp_wr.size()),  32'd0);
        check({tag, "_res_left"}, 32'(exp_res.size()), 32'd0);
        check({tag, "_status"},   32'({done, error, core_rst}), 32'(want));
        check({tag, "_ready"},    32'(byte_ready), 32'd0);
    endtask

    task automatic load_two_word(input logic [7:0] csum);
        stim = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
        stim.push_back(csum);
        exp_wr.push_back({32'h0000_0000, 32'h0010_0513});
        exp_wr.push_back({32'h0000_0004, 32'h0020_0593});
    endtask

    initial begin
        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        check("init_ready", 32'(byte_ready), 32'd0);
        check_reset_outputs("init");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("init_ready_after", 32'(byte_ready), 32'd1);

        // Two-word image, back-to-back. XOR of the ten length+data bytes is 0xB2.
        load_two_word(8'hB2);
        exp_res.push_back(3'b100);
        run_image(1'b0, 1'b1);
        finish_image("t1", 3'b100);

        // Same image with a gap after every byte
        do_reset();
        load_two_word(8'hB2);
        exp_res.push_back(3'b100);
        run_image(1'b1, 1'b0);
        finish_image("t2", 3'b100);

        // Empty image, good checksum
        do_reset();
        stim = '{8'h00, 8'h00, 8'h00};
        exp_res.push_back(3'b100);
        run_image(1'b0, 1'b0);
        finish_image("t3", 3'b100);

        // Empty image, bad checksum
        do_reset();
        stim = '{8'h00, 8'h00, 8'h01};
        exp_res.push_back(3'b011);
        run_image(1'b0, 1'b0);
        finish_image("t4", 3'b011);

        // Length 65 exceeds capacity: error right after LEN1, later bytes ignored
        do_reset();
        exp_res.push_back(3'b011);
        send_byte(8'h41);
        send_byte(8'h00);
        check("t5_error_now", 32'(error), 32'd1);
        check("t5_ready_now", 32'(byte_ready), 32'd0);
        for (int i = 0; i < 8; i++) send_byte(8'(8'h11 * i));
        finish_image("t5", 3'b011);

        // Corrupted checksum: both writes still happen
        do_reset();
        load_two_word(8'hB3);
        exp_res.push_back(3'b011);
        run_image(1'b0, 1'b0);
        finish_image("t6", 3'b011);

        // Reset after 6 data bytes, then full reload from BASE_ADDR
        do_reset();
        exp_wr.push_back({32'h0000_0000, 32'h0010_0513});
        stim = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05};
        run_image(1'b0, 1'b0);
        do_reset();
        check("t7_wr_left_mid", 32'(exp_wr.size()), 32'd0);
        load_two_word(8'hB2);
        exp_res.push_back(3'b100);
        run_image(1'b0, 1'b0);
        finish_image("t7", 3'b100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1);
    end

endmodule
